// File: rtl/epp_wave_engine_if.sv
// Host-side bundle for epp_wave_engine: update control, pixel stream, LUT write
// port and the panel drive pins. Widths follow the engine's PPC and LUT_FRAMES.
interface epp_wave_engine_if #(
    parameter int PPC        = 4,
    parameter int LUT_FRAMES = 20
);
    logic                    start;
    logic                    skip_clean;
    logic                    busy;
    logic                    done;
    logic                    underrun;
    logic [4*PPC-1:0]        pix_data;
    logic                    pix_valid;
    logic                    pix_ready;
    logic                    lut_we;
    logic [3:0]              lut_addr;
    logic [2*LUT_FRAMES-1:0] lut_wdata;
    logic                    epp_ckv;
    logic                    epp_stv;
    logic                    epp_xoe;
    logic                    epp_xstl;
    logic                    epp_xle;
    logic                    epp_mode;
    logic [2*PPC-1:0]        epp_data;

    modport master (
        output start, skip_clean, pix_data, pix_valid, lut_we, lut_addr, lut_wdata,
        input  busy, done, underrun, pix_ready,
        input  epp_ckv, epp_stv, epp_xoe, epp_xstl, epp_xle, epp_mode, epp_data
    );

    modport slave (
        input  start, skip_clean, pix_data, pix_valid, lut_we, lut_addr, lut_wdata,
        output busy, done, underrun, pix_ready,
        output epp_ckv, epp_stv, epp_xoe, epp_xstl, epp_xle, epp_mode, epp_data
    );
endinterface

// File: rtl/epp_wave_engine.sv
// E-paper drive engine: panel gate/source timing plus grey-level to drive-code
// translation through a writable waveform LUT, run as clean frames then LUT frames.
module epp_wave_engine #(
    parameter int PPC          = 4,
    parameter int LSL          = 10,
    parameter int LBL          = 7,
    parameter int LDL          = 240,
    parameter int LEL          = 105,
    parameter int FSL          = 1,
    parameter int FBL          = 4,
    parameter int FDL          = 540,
    parameter int FEL          = 15,
    parameter int GDCK_STA     = 2,
    parameter int GDCK_HI      = 200,
    parameter int LUT_FRAMES   = 20,
    parameter int CLEAN_FRAMES = 15,
    parameter int CLEAN_BLACK  = 8
) (
    input  logic              glb_clk,
    input  logic              glb_rst,
    epp_wave_engine_if.slave  bus
);
    localparam int LTOT  = LSL + LBL + LDL + LEL;
    localparam int FTOT  = FSL + FBL + FDL + FEL;
    localparam int HW    = (LTOT > 1) ? $clog2(LTOT) : 1;
    localparam int VW    = (FTOT > 1) ? $clog2(FTOT) : 1;
    localparam int FMAX  = (CLEAN_FRAMES > LUT_FRAMES) ? CLEAN_FRAMES : LUT_FRAMES;
    localparam int FW    = (FMAX > 1) ? $clog2(FMAX) : 1;
    localparam int D_LO  = FSL + FBL - 1;
    localparam int D_HI  = FSL + FBL + FDL - 1;
    localparam int C_LO  = LSL + LBL;
    localparam int C_HI  = LSL + LBL + LDL;
    localparam int CK_LO = LSL + GDCK_STA;
    localparam int CK_HI = LSL + GDCK_STA + GDCK_HI;

    typedef enum logic [1:0] {IDLE, CLEAN, DRIVE} state_t;

    state_t              state_reg, state_next;
    logic [HW-1:0]       h_reg, h_next;
    logic [VW-1:0]       v_reg, v_next;
    logic [FW-1:0]       f_reg, f_next;
    logic                busy_reg, done_reg, done_next, underrun_reg, underrun_next;
    logic                pix_ready_reg, pix_ready_next;
    logic                ckv_reg, ckv_next, stv_reg, stv_next, xoe_reg, xoe_next;
    logic                xstl_reg, xstl_next, xle_reg, xle_next, mode_reg, mode_next;
    logic [2*PPC-1:0]    data_reg, data_next, lut_code;
    logic [2*LUT_FRAMES-1:0] lut_mem [16];
    int                  h_i, v_i, f_i, lut_shift;
    logic                active, row_d, col_c;

    // Not reset: the LUT is loaded by the host before the first update.
    always_ff @(posedge glb_clk) begin
        if (bus.lut_we && !busy_reg) begin
            lut_mem[bus.lut_addr] <= bus.lut_wdata;
        end
    end

    // Frame 0 of an update reads the MSB pair of the entry.
    always_comb lut_shift = 2 * (LUT_FRAMES - 1 - int'(f_reg));

    generate
        for (genvar gi = 0; gi < PPC; gi++) begin : g_lane
            logic [2*LUT_FRAMES-1:0] lut_word;
            assign lut_word            = lut_mem[bus.pix_data[4*gi +: 4]];
            assign lut_code[2*gi +: 2] = 2'(lut_word >> lut_shift);
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        h_next        = h_reg;
        v_next        = v_reg;
        f_next        = f_reg;
        done_next     = 1'b0;
        underrun_next = underrun_reg;
        if (state_reg == IDLE) begin
            if (bus.start) begin
                state_next    = (bus.skip_clean || CLEAN_FRAMES == 0) ? DRIVE : CLEAN;
                h_next        = '0;
                v_next        = '0;
                f_next        = '0;
                underrun_next = 1'b0;
            end
        end else begin
            if (pix_ready_reg && !bus.pix_valid) begin
                underrun_next = 1'b1;
            end
            if (h_reg == HW'(LTOT - 1)) begin
                h_next = '0;
                if (v_reg == VW'(FTOT - 1)) begin
                    v_next = '0;
                    if (state_reg == CLEAN && f_reg == FW'(CLEAN_FRAMES - 1)) begin
                        state_next = DRIVE;
                        f_next     = '0;
                    end else if (state_reg == DRIVE && f_reg == FW'(LUT_FRAMES - 1)) begin
                        state_next = IDLE;
                        f_next     = '0;
                        done_next  = 1'b1;
                    end else begin
                        f_next = f_reg + 1'b1;
                    end
                end else begin
                    v_next = v_reg + 1'b1;
                end
            end else begin
                h_next = h_reg + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next counter values so the registered pins
    // line up with the counters they describe.
    always_comb begin
        h_i            = int'(h_next);
        v_i            = int'(v_next);
        f_i            = int'(f_next);
        active         = (state_next != IDLE);
        row_d          = (v_i >= D_LO) && (v_i < D_HI);
        col_c          = (h_i >= C_LO) && (h_i < C_HI);
        ckv_next       = active && (h_i >= CK_LO) && (h_i < CK_HI);
        stv_next       = !(active && (v_i < FSL));
        xoe_next       = active && row_d;
        xstl_next      = !(active && row_d && col_c);
        xle_next       = active && (v_i >= FSL + FBL) && (v_i < FSL + FBL + FDL) && (h_i < LSL);
        mode_next      = active && (v_i < D_HI);
        pix_ready_next = (state_next == DRIVE) && row_d && (h_i >= C_LO - 1) && (h_i < C_HI - 1);
        data_next      = '0;
        if (state_next == CLEAN && row_d && col_c) begin
            data_next = (f_i < CLEAN_BLACK) ? {PPC{2'b01}} : {PPC{2'b10}};
        end else if (state_next == DRIVE && row_d && col_c && pix_ready_reg && bus.pix_valid) begin
            data_next = lut_code;
        end
    end

    always_ff @(posedge glb_clk) begin
        if (glb_rst) begin
            state_reg     <= IDLE;
            h_reg         <= '0;
            v_reg         <= '0;
            f_reg         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            underrun_reg  <= 1'b0;
            pix_ready_reg <= 1'b0;
            ckv_reg       <= 1'b0;
            stv_reg       <= 1'b1;
            xoe_reg       <= 1'b0;
            xstl_reg      <= 1'b1;
            xle_reg       <= 1'b0;
            mode_reg      <= 1'b0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            h_reg         <= h_next;
            v_reg         <= v_next;
            f_reg         <= f_next;
            busy_reg      <= (state_next != IDLE);
            done_reg      <= done_next;
            underrun_reg  <= underrun_next;
            pix_ready_reg <= pix_ready_next;
            ckv_reg       <= ckv_next;
            stv_reg       <= stv_next;
            xoe_reg       <= xoe_next;
            xstl_reg      <= xstl_next;
            xle_reg       <= xle_next;
            mode_reg      <= mode_next;
            data_reg      <= data_next;
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.underrun  = underrun_reg;
    assign bus.pix_ready = pix_ready_reg;
    assign bus.epp_ckv   = ckv_reg;
    assign bus.epp_stv   = stv_reg;
    assign bus.epp_xoe   = xoe_reg;
    assign bus.epp_xstl  = xstl_reg;
    assign bus.epp_xle   = xle_reg;
    assign bus.epp_mode  = mode_reg;
    assign bus.epp_data  = data_reg;
endmodule

// File: tb/tb_epp_wave_engine.sv
// Directed bench for epp_wave_engine on a 10x6 raster with 2 clean and 3 LUT
// frames; each cycle of an update is recorded, then checked against hand values.
module tb_epp_wave_engine;
    logic glb_clk = 1'b0;
    logic glb_rst;
    int   errors = 0;
    int   checks = 0;

    epp_wave_engine_if #(.PPC(4), .LUT_FRAMES(3)) bus ();

    epp_wave_engine #(
        .PPC(4), .LSL(2), .LBL(2), .LDL(4), .LEL(2),
        .FSL(1), .FBL(1), .FDL(3), .FEL(1),
        .GDCK_STA(1), .GDCK_HI(6),
        .LUT_FRAMES(3), .CLEAN_FRAMES(2), .CLEAN_BLACK(1)
    ) dut (
        .glb_clk (glb_clk),
        .glb_rst (glb_rst),
        .bus     (bus)
    );

    always #5 glb_clk = ~glb_clk;

    // Per-cycle record of one update; index k=1 is the first cycle after start.
    logic [7:0] r_data [0:399];
    logic       r_busy [0:399];
    logic       r_done [0:399];
    logic       r_ur   [0:399];
    logic       r_rdy  [0:399];
    logic       r_ckv  [0:399];
    logic       r_stv  [0:399];
    logic       r_xoe  [0:399];
    logic       r_xstl [0:399];
    logic       r_xle  [0:399];
    logic       r_mode [0:399];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int idx(input int f, input int v, input int h);
        return 60 * f + 10 * v + h + 1;
    endfunction

    task automatic lut_write(input logic [3:0] addr, input logic [5:0] data);
        bus.lut_we    = 1'b1;
        bus.lut_addr  = addr;
        bus.lut_wdata = data;
        @(posedge glb_clk); #1;
        bus.lut_we    = 1'b0;
    endtask

    // Start an update, then record ncyc cycles. drop_n/start_n/lutw_n/rst_n give the
    // cycle offset n=k-1 at which pix_valid drops, start, a LUT write or glb_rst is applied.
    task automatic run(input string name, input logic skip, input logic [15:0] pix,
                       input int drop_n, input int start_n, input int lutw_n,
                       input int rst_n, input int ncyc);
        bus.start      = 1'b1;
        bus.skip_clean = skip;
        bus.pix_data   = pix;
        bus.pix_valid  = 1'b1;
        @(posedge glb_clk); #1;
        bus.start      = 1'b0;
        bus.skip_clean = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            r_data[k] = bus.epp_data;
            r_busy[k] = bus.busy;
            r_done[k] = bus.done;
            r_ur[k]   = bus.underrun;
            r_rdy[k]  = bus.pix_ready;
            r_ckv[k]  = bus.epp_ckv;
            r_stv[k]  = bus.epp_stv;
            r_xoe[k]  = bus.epp_xoe;
            r_xstl[k] = bus.epp_xstl;
            r_xle[k]  = bus.epp_xle;
            r_mode[k] = bus.epp_mode;
            bus.pix_valid = (k - 1 != drop_n);
            bus.start     = (k - 1 == start_n);
            bus.lut_we    = (k - 1 == lutw_n);
            bus.lut_addr  = 4'd5;
            bus.lut_wdata = 6'h3f;
            glb_rst       = (k - 1 == rst_n);
            @(posedge glb_clk); #1;
        end
        bus.start     = 1'b0;
        bus.lut_we    = 1'b0;
        bus.pix_valid = 1'b1;
        glb_rst       = 1'b0;
        $display("update %s: %0d cycles recorded, skip_clean=%0b pix=%h", name, ncyc, skip, pix);
    endtask

    initial begin
        int cnt;
        int act;
        glb_rst        = 1'b1;
        bus.start      = 1'b0;
        bus.skip_clean = 1'b0;
        bus.pix_data   = '0;
        bus.pix_valid  = 1'b0;
        bus.lut_we     = 1'b0;
        bus.lut_addr   = '0;
        bus.lut_wdata  = '0;
        repeat (3) @(posedge glb_clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_underrun", bus.underrun, 0);
        chk("rst_ready", bus.pix_ready, 0);
        chk("rst_ckv", bus.epp_ckv, 0);
        chk("rst_stv", bus.epp_stv, 1);
        chk("rst_xoe", bus.epp_xoe, 0);
        chk("rst_xstl", bus.epp_xstl, 1);
        chk("rst_xle", bus.epp_xle, 0);
        chk("rst_mode", bus.epp_mode, 0);
        chk("rst_data", bus.epp_data, 0);
        glb_rst = 1'b0;
        act = 0;
        repeat (50) begin
            @(posedge glb_clk); #1;
            if (bus.busy || bus.done || bus.pix_ready || bus.epp_ckv || !bus.epp_stv ||
                bus.epp_xoe || !bus.epp_xstl || bus.epp_xle || bus.epp_mode || bus.epp_data != 0)
                act++;
        end
        chk("idle_quiet", act, 0);

        lut_write(4'd5, 6'b01_10_00);
        lut_write(4'd3, 6'b10_01_00);

        // Full update: 2 clean frames + 3 LUT frames.
        run("A", 1'b0, 16'h5555, -1, -1, -1, -1, 310);
        cnt = 0;
        for (int k = 1; k <= 300; k++) cnt += int'(r_busy[k]);
        chk("A_busy_cycles", cnt, 300);
        chk("A_busy_301", r_busy[301], 0);
        chk("A_done_301", r_done[301], 1);
        cnt = 0;
        for (int k = 1; k <= 310; k++) cnt += int'(r_done[k]);
        chk("A_done_count", cnt, 1);
        chk("A_first_stv", r_stv[1], 0);
        chk("A_clean_black", r_data[idx(0, 1, 4)], 8'h55);
        chk("A_clean_white", r_data[idx(1, 2, 5)], 8'hAA);
        chk("A_drive_f0", r_data[idx(2, 1, 4)], 8'h55);
        chk("A_drive_f1", r_data[idx(3, 3, 7)], 8'hAA);
        chk("A_drive_f2", r_data[idx(4, 2, 6)], 8'h00);
        chk("A_data_h3", r_data[idx(2, 1, 3)], 8'h00);
        chk("A_data_h8", r_data[idx(2, 1, 8)], 8'h00);
        chk("A_data_v0", r_data[idx(2, 0, 5)], 8'h00);
        for (int f = 0; f < 5; f++) begin
            cnt = 0;
            for (int k = idx(f, 0, 0); k <= idx(f, 5, 9); k++) cnt += int'(r_rdy[k]);
            chk($sformatf("A_ready_f%0d", f), cnt, (f < 2) ? 0 : 12);
        end
        begin
            int n_xstl, n_ckv, n_xle, n_stv, n_xoe, n_mode;
            n_xstl = 0; n_ckv = 0; n_xle = 0; n_stv = 0; n_xoe = 0; n_mode = 0;
            for (int k = idx(2, 0, 0); k <= idx(2, 5, 9); k++) begin
                n_xstl += int'(!r_xstl[k]);
                n_ckv  += int'(r_ckv[k]);
                n_xle  += int'(r_xle[k]);
                n_stv  += int'(!r_stv[k]);
                n_xoe  += int'(r_xoe[k]);
                n_mode += int'(r_mode[k]);
            end
            chk("A_xstl_low_count", n_xstl, 12);
            chk("A_ckv_count", n_ckv, 36);
            chk("A_xle_count", n_xle, 6);
            chk("A_stv_low_count", n_stv, 10);
            chk("A_xoe_count", n_xoe, 30);
            chk("A_mode_count", n_mode, 40);
        end
        chk("A_xstl_v1h4", r_xstl[idx(2, 1, 4)], 0);
        chk("A_xstl_v1h7", r_xstl[idx(2, 1, 7)], 0);
        chk("A_xstl_v1h8", r_xstl[idx(2, 1, 8)], 1);
        chk("A_xle_v2h0", r_xle[idx(2, 2, 0)], 1);
        chk("A_xle_v2h1", r_xle[idx(2, 2, 1)], 1);
        chk("A_xle_v1h0", r_xle[idx(2, 1, 0)], 0);
        chk("A_xle_v5h0", r_xle[idx(2, 5, 0)], 0);
        chk("A_ckv_h3", r_ckv[idx(2, 0, 3)], 1);
        chk("A_ckv_h8", r_ckv[idx(2, 0, 8)], 1);
        chk("A_ckv_h9", r_ckv[idx(2, 0, 9)], 0);
        chk("A_ckv_h2", r_ckv[idx(2, 0, 2)], 0);
        chk("A_stv_v1", r_stv[idx(2, 1, 0)], 1);
        chk("A_mode_v3", r_mode[idx(2, 3, 9)], 1);
        chk("A_mode_v4", r_mode[idx(2, 4, 0)], 0);
        chk("A_xoe_v4", r_xoe[idx(2, 4, 5)], 0);
        chk("A_idle_stv", r_stv[305], 1);

        // Lane mapping, one dropped word, and a start while busy.
        run("B", 1'b1, 16'h3535, idx(0, 1, 3) - 1, 30, -1, -1, 190);
        chk("B_ur_before", r_ur[idx(0, 1, 3)], 0);
        chk("B_ur_set", r_ur[idx(0, 1, 4)], 1);
        chk("B_drop_data", r_data[idx(0, 1, 4)], 8'h00);
        chk("B_lanes_f0", r_data[idx(0, 1, 5)], 8'h99);
        chk("B_lanes_f1", r_data[idx(1, 2, 7)], 8'h66);
        chk("B_lanes_f2", r_data[idx(2, 1, 4)], 8'h00);
        chk("B_busy_180", r_busy[180], 1);
        chk("B_busy_181", r_busy[181], 0);
        chk("B_done_181", r_done[181], 1);
        chk("B_ur_sticky", r_ur[185], 1);
        cnt = 0;
        for (int k = 1; k <= 190; k++) cnt += int'(r_done[k]);
        chk("B_done_count", cnt, 1);

        // LUT write while busy, then glb_rst in frame 1.
        run("C", 1'b1, 16'h5555, -1, -1, 5, 70, 80);
        chk("C_ur_cleared", r_ur[1], 0);
        chk("C_busy_k1", r_busy[1], 1);
        chk("C_busy_71", r_busy[71], 1);
        chk("C_busy_72", r_busy[72], 0);
        chk("C_stv_72", r_stv[72], 1);
        chk("C_xstl_72", r_xstl[72], 1);
        chk("C_mode_72", r_mode[72], 0);
        chk("C_ckv_72", r_ckv[72], 0);
        cnt = 0;
        for (int k = 1; k <= 80; k++) cnt += int'(r_done[k]);
        chk("C_no_done", cnt, 0);

        run("D", 1'b1, 16'h5555, -1, -1, -1, -1, 20);
        chk("D_lut_kept", r_data[idx(0, 1, 4)], 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
